// File: rtl/execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | execute_stage : RISC-V EX stage - forwarding, ALU, branch resolve, EX/MEM  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module execute_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              ALUSrcE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic [2:0]        ALUControlE,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Imm_Ext_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              HoldM,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   ALU_ResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] b_operand;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Select 10 taps the registered EX/MEM result, so a held stage keeps feeding it.
  always_comb begin
    src_a = RD1_E;
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b     = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign b_operand = ALUControlE[0] ? ~src_b : src_b;
  assign sum       = src_a + b_operand + {{(XLEN-1){1'b0}}, ALUControlE[0]};

  // SLT is the raw sign of the difference; overflow is deliberately not corrected.
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD: alu_result = sum;
      ALU_SUB: alu_result = sum;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, sum[XLEN-1]};
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCSrcE    = (BranchE & zero) | JumpE;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 2'b00;
      RD_M        <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end else if (!HoldM) begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      ALU_ResultM <= alu_result;
      WriteDataM  <= fwd_b;
      PCPlus4M    <= PCPlus4E;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// tb_execute_stage : directed vectors, expected EX/MEM contents queued and checked by a monitor.
module tb_execute_stage;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } mstate_t;

  typedef struct packed {
    logic        rw, mw;
    logic [1:0]  rs;
    logic        alusrc, br, jmp;
    logic [2:0]  ctl;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd;
    logic [1:0]  fa, fb;
    logic        hold;
  } ex_t;

  logic        clk, rst;
  logic        RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, HoldM;
  logic [1:0]  ResultSrcE, ForwardA_E, ForwardB_E;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE, RegWriteM, MemWriteM;
  logic [31:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;

  mstate_t act_m;
  assign act_m = {RegWriteM, MemWriteM, ResultSrcM, RD_M, ALU_ResultM, WriteDataM, PCPlus4M};

  int total = 0;
  int bad   = 0;
  mstate_t q[$];
  mstate_t last_exp;

  execute_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .HoldM(HoldM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RD_M(RD_M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expected EX/MEM snapshot per clock edge that had stimulus queued.
  initial begin
    mstate_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (act_m !== e) begin
          bad++;
          $display("FAIL ex_mem_reg: got %h want %h", act_m, e);
        end
      end
    end
  end

  function automatic ex_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    ex_t v;
    v = '0;
    v.rw = 1'b1; v.rd1 = a; v.rd2 = b; v.ctl = c;
    v.rd = 5'd3; v.pc = 32'h100; v.pc4 = 32'h104;
    return v;
  endfunction

  task automatic drive(input ex_t v);
    RegWriteE = v.rw; MemWriteE = v.mw; ResultSrcE = v.rs; ALUSrcE = v.alusrc;
    BranchE = v.br; JumpE = v.jmp; ALUControlE = v.ctl; RD1_E = v.rd1; RD2_E = v.rd2;
    Imm_Ext_E = v.imm; PCE = v.pc; PCPlus4E = v.pc4; RD_E = v.rd;
    ForwardA_E = v.fa; ForwardB_E = v.fb; HoldM = v.hold;
  endtask

  task automatic push_exp(input ex_t v, input logic [31:0] e_alu, input logic [31:0] e_wd);
    if (!v.hold) last_exp = '{rw: v.rw, mw: v.mw, rs: v.rs, rd: v.rd, alu: e_alu, wd: e_wd, pc4: v.pc4};
    q.push_back(last_exp);
  endtask

  task automatic exec(input ex_t v, input logic [31:0] e_alu, input logic [31:0] e_wd);
    @(negedge clk);
    drive(v);
    #1;
    push_exp(v, e_alu, e_wd);
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if (act_m !== '0) begin
      bad++;
      $display("FAIL %s: got %h want 0", name, act_m);
    end
  endtask

  // Async assert mid-cycle, hold low over an edge, release together with the first vector.
  task automatic reset_seq(input ex_t v, input logic [31:0] e_alu, input logic [31:0] e_wd);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    drive(v);
    #1;
    check_zero("rst_release");
    push_exp(v, e_alu, e_wd);
  endtask

  initial begin
    ex_t v;
    rst = 1'b1;
    ResultW = 32'h20;
    last_exp = '0;
    v = mk(32'd5, 32'd7, 3'b000);
    v.mw = 1'b1; v.rs = 2'b10;
    drive(v);
    repeat (2) @(posedge clk);

    // Arithmetic: 5 op 7
    reset_seq(mk(32'd5, 32'd7, 3'b000), 32'd12, 32'd7);
    exec(mk(32'd5, 32'd7, 3'b001), 32'hFFFF_FFFE, 32'd7);
    exec(mk(32'd5, 32'd7, 3'b101), 32'd1, 32'd7);
    exec(mk(32'd5, 32'd7, 3'b010), 32'd5, 32'd7);
    exec(mk(32'd5, 32'd7, 3'b011), 32'd7, 32'd7);
    exec(mk(32'd5, 32'd7, 3'b100), 32'd0, 32'd7);
    exec(mk(32'h8000_0000, 32'd1, 3'b101), 32'd0, 32'd1);

    // Forwarding: seed ALU_ResultM=0x10, ResultW=0x20, RD1=0x30
    v = mk(32'h10, 32'h55, 3'b000); v.alusrc = 1'b1;
    exec(v, 32'h10, 32'h55);
    v = mk(32'h30, 32'h55, 3'b000); v.alusrc = 1'b1; v.imm = 32'd1;
    v.fa = 2'b10; exec(v, 32'h11, 32'h55);
    v.fa = 2'b01; exec(v, 32'h21, 32'h55);
    v.fa = 2'b00; exec(v, 32'h31, 32'h55);
    v.fa = 2'b11; exec(v, 32'h31, 32'h55);
    v.fb = 2'b01; exec(v, 32'h31, 32'h20);
    v.fb = 2'b10; exec(v, 32'h31, 32'h31);

    // Branch / jump resolution
    v = mk(32'd9, 32'd9, 3'b001); v.rw = 1'b0; v.br = 1'b1; v.imm = 32'hFFFF_FFF0;
    exec(v, 32'd0, 32'd9);
    check_val("beq_taken", {31'd0, PCSrcE}, 32'd1);
    check_val("br_target", PCTargetE, 32'h0000_00F0);
    v.rd2 = 32'd8;
    exec(v, 32'd1, 32'd8);
    check_val("beq_not_taken", {31'd0, PCSrcE}, 32'd0);
    v.br = 1'b0; v.jmp = 1'b1;
    exec(v, 32'd1, 32'd8);
    check_val("jal", {31'd0, PCSrcE}, 32'd1);

    // Hold for 3 edges while inputs change, then forward the held result
    v = mk(32'd3, 32'd4, 3'b000); v.mw = 1'b1; v.rs = 2'b01; v.rd = 5'd7; v.pc4 = 32'h208;
    exec(v, 32'd7, 32'd4);
    for (int i = 0; i < 3; i++) begin
      v = mk(32'd100 + i, 32'd50, 3'b001); v.rd = 5'd1 + 5'(i); v.pc4 = 32'h300 + i; v.hold = 1'b1;
      exec(v, 32'd0, 32'd0);
    end
    v = mk(32'd10, 32'd20, 3'b001); v.mw = 1'b0; v.rs = 2'b10; v.rd = 5'd9; v.pc4 = 32'h20C;
    v.fa = 2'b10;
    exec(v, 32'hFFFF_FFF3, 32'd20);

    // Wrap-around of target adder and ALU
    v = mk(32'hFFFF_FFFF, 32'd1, 3'b000); v.pc = 32'hFFFF_FFFC; v.imm = 32'd8;
    exec(v, 32'd0, 32'd1);
    check_val("target_wrap", PCTargetE, 32'h0000_0004);
    check_val("pcsrc_idle", {31'd0, PCSrcE}, 32'd0);

    // Reset in the middle of traffic
    v = mk(32'h1234, 32'h1, 3'b011); v.mw = 1'b1; v.rd = 5'd31;
    exec(v, 32'h1235, 32'h1);
    reset_seq(mk(32'd2, 32'd3, 3'b000), 32'd5, 32'd3);

    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RISC-V pipeline.
- Consumes ID/EX control and data, resolves operand forwarding, and computes the ALU result and flags.
- Resolves branch/jump redirect and target combinationally.
- Registers results into the EX/MEM pipeline register that feeds the memory stage.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteE  in  1  register write enable for the EX instruction.
- MemWriteE  in  1  store enable.
- ResultSrcE  in  2  writeback select: 00 ALU, 01 memory, 10 PC+4.
- ALUSrcE  in  1  0: SrcB = forwarded RD2; 1: SrcB = immediate.
- BranchE  in  1  conditional branch (beq).
- JumpE  in  1  unconditional jump (jal).
- ALUControlE  in  3  ALU operation.
- RD1_E, RD2_E  in  XLEN  register-file read data.
- Imm_Ext_E  in  XLEN  sign-extended immediate.
- PCE, PCPlus4E  in  XLEN  instruction PC and PC+4.
- RD_E  in  REG_AW  destination register.
- ForwardA_E, ForwardB_E  in  2  hazard-unit forwarding selects.
- ResultW  in  XLEN  writeback-stage result for forwarding.
- HoldM  in  1  memory stall; freezes the EX/MEM register.
- PCSrcE  out  1  redirect fetch (combinational).
- PCTargetE  out  XLEN  branch/jump target (combinational).
- RegWriteM, MemWriteM  out  1  registered control.
- ResultSrcM  out  2  registered control.
- RD_M  out  REG_AW  registered destination.
- ALU_ResultM, WriteDataM, PCPlus4M  out  XLEN  registered data.

Behaviour:
- Forward mux A:
  - 00 → RD1_E; 01 → ResultW; 10 → ALU_ResultM (registered output); 11 → RD1_E.
  - SrcA = mux A output.
- Forward mux B: same selects on RD2_E. Result is FwdB.
- SrcB = ALUSrcE ? Imm_Ext_E : FwdB.
- Sum:
  - ALUControlE[0]=0: SrcA+SrcB.
  - ALUControlE[0]=1: SrcA+(~SrcB)+1.
  - Mod 2^XLEN.
- ALU result:
  - 000 add; 001 sub; 010 AND; 011 OR.
  - 101 SLT = {XLEN-1 zeros, Sum[XLEN-1]}. Sign-of-difference only; no overflow correction.
  - All other codes → 0.
- ZeroE = (ALU result == 0).
- PCSrcE = (BranchE & ZeroE) | JumpE. Purely combinational from current EX inputs.
- PCTargetE = PCE + Imm_Ext_E, wraps mod 2^XLEN.
- EX/MEM register:
  - rst low (any time, asynchronous) → all M outputs 0 immediately. Held while low.
  - First capture is the first rising clk after rst deasserts.
  - Rising clk with HoldM=0 → capture:
    - RegWriteM ← RegWriteE, MemWriteM ← MemWriteE, ResultSrcM ← ResultSrcE, RD_M ← RD_E.
    - ALU_ResultM ← ALU result, WriteDataM ← FwdB, PCPlus4M ← PCPlus4E.
  - Rising clk with HoldM=1 → all M outputs keep their value.
  - While held, forward select 10 still supplies the held ALU_ResultM.
- Latency:
  - ALU result visible on ALU_ResultM 1 cycle after EX inputs are presented.
  - PCSrcE/PCTargetE have 0-cycle latency.
- Flushing of EX is upstream's job (bubble = RegWriteE=MemWriteE=BranchE=JumpE=0). This block has no flush input.
- WriteDataM is FwdB even when ALUSrcE=1 (store data path).
- Reset mid-operation: the in-flight EX/MEM entry is discarded. RegWriteM=MemWriteM=0 guarantees no architectural side effect.

Test Plan:
- Reset: drive rst=0 mid-cycle with non-zero EX inputs → all M outputs 0 at once. They stay 0 until the first clk edge after rst=1.
- Add/sub/SLT: SrcA=5, RD2=7, ALUSrcE=0:
  - ctl 000 → ALU_ResultM=12 next cycle.
  - ctl 001 → 0xFFFFFFFE.
  - ctl 101 → 1.
  - SrcA=0x80000000, SrcB=1, ctl 101 → 0 (documented no-overflow-correction behaviour).
- Forwarding:
  - ALU_ResultM=0x10, ResultW=0x20, RD1=0x30.
  - ForwardA=10/01/00/11 with ctl 000, Imm=1, ALUSrcE=1 → results 0x11/0x21/0x31/0x31.
  - ForwardB=01 with ALUSrcE=1 → WriteDataM=0x20.
- Branch:
  - BranchE=1, SrcA=SrcB=9, ctl 001 → PCSrcE=1 in the same cycle; PCE=0x100, Imm=0xFFFFFFF0 → PCTargetE=0xF0.
  - SrcB=8 → PCSrcE=0.
  - JumpE=1 with BranchE=0 → PCSrcE=1.
- Hold: HoldM=1 for 3 cycles while EX inputs change → M outputs constant. On release, the next edge captures the current EX values.
- Wrap: PCE=0xFFFFFFFC, Imm=8 → PCTargetE=0x4. SrcA=0xFFFFFFFF add 1 → ALU_ResultM=0.
